// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command stream to single APB4 transfers, one outstanding.
// Define APB_CMD_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles without PREADY.
module apb_cmd_master #(
  parameter int ADDRWIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_strb,
  input  logic [2:0]           cmd_prot,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  output logic [2:0]           PPROT,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t               state_q;
  logic                 psel_q, penable_q, pwrite_q, rsp_valid_q, rsp_err_q, rsp_to_q;
  logic [ADDRWIDTH-1:0] paddr_q;
  logic [31:0]          pwdata_q, rdata_q;
  logic [3:0]           pstrb_q;
  logic [2:0]           pprot_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  logic [15:0]          cnt_q;
`endif
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be 1..65535");
  end
  assign cmd_ready   = (state_q == IDLE) && !PRESET;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          paddr_q  <= cmd_addr & ~ADDRWIDTH'(3);
          pwrite_q <= cmd_write;
          pwdata_q <= cmd_wdata;
          pstrb_q  <= cmd_write ? cmd_strb : 4'b0000;
          pprot_q  <= cmd_prot;
          psel_q   <= 1'b1;
          state_q  <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          cnt_q     <= '0;
`endif
        end
        ACCESS: if (PREADY) begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rdata_q     <= pwrite_q ? 32'h0 : PRDATA;
          rsp_err_q   <= PSLVERR;
          rsp_to_q    <= 1'b0;
          state_q     <= RESP;
        end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        // counter would reach TIMEOUT on this edge with the slave still stalling
        else if (cnt_q == 16'(TIMEOUT - 1)) begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rdata_q     <= 32'h0;
          rsp_err_q   <= 1'b1;
          rsp_to_q    <= 1'b1;
          state_q     <= RESP;
        end else cnt_q <= cnt_q + 16'd1;
`endif
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: scoreboard bench with a stalling APB slave model and random commands.
module tb_apb_cmd_master;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif
  logic        PCLK = 0, PRESET = 1;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [15:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic [3:0]  cmd_strb = 0;
  logic [2:0]  cmd_prot = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA, PRDATA = 0;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY = 0, PSLVERR = 0;

  apb_cmd_master #(.ADDRWIDTH(16), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .PSEL(PSEL), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct { logic [31:0] rdata; logic err; logic to; int lat; } exp_t;
  typedef struct { logic [15:0] addr; logic write; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot; } bus_t;
  typedef struct { int waits; logic [31:0] rdata; logic err; } sl_t;
  exp_t exp_q[$];
  bus_t bus_q[$];
  sl_t  sl_q[$];
  bus_t cur_bus;
  sl_t  cur_sl;
  int   n_chk = 0, n_fail = 0;
  int   wleft = 0, since = -1;
  logic prev_rv = 0, rr_force_en = 0, rr_force = 0;
  logic [15:0] last_addr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  // slave: loads per-transfer behaviour in SETUP, stalls the requested number of ACCESS cycles
  always @(posedge PCLK) begin
    #1;
    if (PSEL && !PENABLE) begin
      if (sl_q.size() != 0) cur_sl = sl_q.pop_front();
      if (bus_q.size() != 0) cur_bus = bus_q.pop_front();
      wleft = cur_sl.waits;
      PREADY = 0;
    end else if (PSEL && PENABLE) begin
      PREADY = (wleft == 0);
      if (wleft > 0) wleft--;
    end else PREADY = 1'($urandom_range(0, 1));
    PRDATA  = PREADY ? cur_sl.rdata : $urandom;
    PSLVERR = PREADY ? cur_sl.err : 1'($urandom_range(0, 1));
  end

  always @(posedge PCLK) begin
    #2;
    rsp_ready = rr_force_en ? rr_force : ($urandom_range(0, 3) != 0);
  end

  // monitor: phase timing, bus contents and response scoreboard
  always @(negedge PCLK) begin
    if (PRESET) prev_rv = 0;
    else begin
      if (since >= 0) since++;
      if (since == 1) begin chk("setup_psel", PSEL, 1); chk("setup_penable", PENABLE, 0); end
      if (since == 2) begin chk("access_psel", PSEL, 1); chk("access_penable", PENABLE, 1); end
      if (PSEL) begin
        chk("paddr", PADDR, cur_bus.addr);
        chk("pwrite", PWRITE, cur_bus.write);
        chk("pwdata", PWDATA, cur_bus.wdata);
        chk("pstrb", PSTRB, cur_bus.strb);
        chk("pprot", PPROT, cur_bus.prot);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          if (!prev_rv) chk("latency", since, exp_q[0].lat);
          chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          chk("rsp_err", rsp_err, exp_q[0].err);
          chk("rsp_timeout", rsp_timeout, exp_q[0].to);
          chk("cmd_ready_busy", cmd_ready, 0);
          chk("psel_in_resp", PSEL, 0);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      prev_rv = rsp_valid;
      if (cmd_valid && cmd_ready) since = 0;
    end
  end

  task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p, input int waits, input logic [31:0] rd, input logic er);
    exp_t e;
    int   n = 0;
    e.rdata = w ? 32'h0 : rd;
    e.err   = er;
    e.to    = 0;
    e.lat   = 3 + waits;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    if (waits >= TMO) begin e.rdata = 0; e.err = 1; e.to = 1; e.lat = 2 + TMO; end
`endif
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p; cmd_valid = 1;
    do begin @(negedge PCLK); n++; end while (!cmd_ready && n < 200);
    if (!cmd_ready) chk("accept_timeout", cmd_ready, 1);
    else begin
      exp_q.push_back(e);
      bus_q.push_back('{addr: a & 16'hFFFC, write: w, wdata: d, strb: w ? s : 4'h0, prot: p});
      sl_q.push_back('{waits: waits, rdata: rd, err: er});
      last_addr = a & 16'hFFFC;
    end
    tick;
    cmd_valid = $urandom_range(0, 1);
    cmd_write = 1'($urandom); cmd_addr = 16'($urandom); cmd_wdata = $urandom;
    cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
    cmd_valid = 0;
  endtask

  task automatic drain;
    int n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 500) begin tick; n++; end
    if (n >= 500) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset;
    PRESET = 1;
    exp_q.delete(); bus_q.delete(); sl_q.delete();
    @(negedge PCLK);
    chk("cmd_ready_in_reset", cmd_ready, 0);
    tick;
    PRESET = 0;
    @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("cmd_ready_in_reset", cmd_ready, 0);
    tick;
    PRESET = 0;
    @(negedge PCLK);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pstrb", PSTRB, 0);
    chk("rst_pprot", PPROT, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    tick;
    send(1, 16'h1008, 32'hA5A5_0001, 4'hF, 3'd0, 0, 32'h0, 0);
    drain;
    send(0, 16'h2003, 32'h1234_5678, 4'hF, 3'd2, 3, 32'hDEAD_BEEF, 0);
    drain;
    rr_force_en = 1; rr_force = 0;
    send(0, 16'h3010, 32'h0, 4'h0, 3'd5, 1, 32'hCAFE_F00D, 1);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge PCLK); n++; end
    chk("hold_reached", rsp_valid, 1);
    repeat (5) @(negedge PCLK);
    chk("hold_rsp_valid", rsp_valid, 1);
    tick;
    rr_force = 1;
    drain;
    rr_force_en = 0;
    send(0, 16'h4000, 32'h0, 4'h0, 3'd1, 5, 32'h1111_2222, 0);
    n = 0;
    while (!PENABLE && n < 50) begin @(negedge PCLK); n++; end
    chk("reached_access", PENABLE, 1);
    tick;
    do_reset;
    send(1, 16'h0104, 32'h0BAD_CAFE, 4'h5, 3'd3, 0, 32'h0, 0);
    drain;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    send(0, 16'h5004, 32'h0, 4'h0, 3'd0, TMO - 1, 32'h7777_8888, 0);
    drain;
    send(0, 16'h5008, 32'h0, 4'h0, 3'd0, TMO, 32'h9999_AAAA, 0);
    drain;
    send(1, 16'h500C, 32'h1357_9BDF, 4'hC, 3'd4, 1000, 32'h0, 0);
    drain;
`else
    send(0, 16'h5004, 32'h0, 4'h0, 3'd0, 100000, 32'h7777_8888, 0);
    repeat (100) @(negedge PCLK);
    chk("stuck_psel", PSEL, 1);
    chk("stuck_penable", PENABLE, 1);
    chk("stuck_no_rsp", rsp_valid, 0);
    tick;
    do_reset;
`endif
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom), 16'($urandom), $urandom, 4'($urandom), 3'($urandom),
           $urandom_range(0, 4), $urandom, 1'($urandom));
      repeat ($urandom_range(0, 2)) tick;
    end
    drain;
    @(negedge PCLK);
    chk("paddr_held", PADDR, last_addr);
    chk("idle_psel", PSEL, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB4 initiator (requester) converting a simple valid/ready command stream into single APB transfers.
- Drives the same PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT bus that the subsystem's APB slaves (UART, GPIO) respond on.
- Used by a debug loader / DMA-style engine to reach APB peripherals without the AHB bridge.
- One outstanding transfer at a time; response returned on a valid/ready channel.

Parameters:
ADDRWIDTH, 16, width of cmd_addr and PADDR
TIMEOUT, 255, max ACCESS-phase cycles waiting for PREADY before abort (only with optional feature); must be 1..65535

Ports:
PCLK  input  1  clock; all logic on rising edge
PRESET  input  1  synchronous reset, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDRWIDTH  byte address; bits [1:0] ignored
cmd_wdata  input  32  write data
cmd_strb  input  4  write byte strobes
cmd_prot  input  3  protection, passed to PPROT
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready
rsp_rdata  output  32  read data (0 for writes)
rsp_err  output  1  PSLVERR of transfer, or timeout
rsp_timeout  output  1  transfer aborted by timeout
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PADDR  output  ADDRWIDTH  APB address, [1:0] forced 2'b00
PWRITE  output  1  APB direction
PWDATA  output  32  APB write data
PSTRB  output  4  APB strobes; 4'b0000 on reads
PPROT  output  3  APB protection
PRDATA  input  32  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB error

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset (PRESET=1 at a PCLK edge) -> IDLE.
- Reset values: cmd_ready=0 during the reset cycle, then 1 in IDLE. PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, PPROT=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
- All outputs are registered except cmd_ready, which is (state==IDLE).
- IDLE: on handshake at edge N, register addr/write/wdata/strb/prot and go to SETUP.
- SETUP (cycle N+1): PSEL=1, PENABLE=0. Next state is ACCESS unconditionally.
- ACCESS (cycle N+2 onward): PSEL=1, PENABLE=1. All bus outputs are held stable until PREADY=1.
- ACCESS completion: edge with PREADY=1 captures rsp_rdata (PRDATA on reads, 0 on writes) and rsp_err=PSLVERR, then goes to RESP.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1. rsp_* is held stable until rsp_ready=1, then goes to IDLE.
- Minimum turnaround: accept -> rsp_valid is 3 cycles with a zero-wait-state slave. Accept-to-accept is 4 cycles when rsp_ready is tied high.
- rsp_ready while rsp_valid=0 is ignored. cmd_valid outside IDLE is ignored; the command is not lost because cmd_ready=0.
- PADDR/PWRITE/PWDATA/PSTRB/PPROT keep their last value after the transfer. Only PSEL/PENABLE return to 0.
- Reset mid-transfer, in any state: next cycle PSEL=PENABLE=0, rsp_valid=0, pending response discarded, FSM in IDLE.

Optional Feature:
- Macro: APB_CMD_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT with PREADY still 0: PSEL/PENABLE drop next cycle, FSM goes to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the same edge the counter reaches TIMEOUT wins: normal completion, rsp_timeout=0.
- Without the macro: no counter; ACCESS waits indefinitely; rsp_timeout is tied 0.

Test Plan:
- Reset, then write addr 16'h1008, wdata 32'hA5A5_0001, strb 4'hF, zero-wait slave -> PSEL rises 1 cycle after accept, PENABLE 1 cycle later, PADDR=16'h1008, PSTRB=4'hF; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read addr 16'h2003 with slave holding PREADY=0 for 3 cycles, PRDATA=32'hDEAD_BEEF -> PADDR=16'h2000, PSTRB=0, ACCESS lasts 4 cycles with all bus outputs stable, rsp_rdata=32'hDEAD_BEEF.
- Read with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0. Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0 throughout.
- PRESET asserted during ACCESS -> next cycle PSEL=PENABLE=rsp_valid=0, cmd_ready=1 one cycle after PRESET deasserts. A following write completes normally.
- With APB_CMD_MASTER_TIMEOUT_EN and TIMEOUT=8, PREADY stuck 0 -> PSEL drops after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Without the macro -> still in ACCESS after 100 cycles.
